m_round_timer_ctrl: RTL
=======================

Name: m_round_timer_ctrl

Overview:
- Countdown controller for the game-round clock. Divides the system clock into a one-second enable, then sequences a BCD M:SS display register down to 0:00.
- Supports load, start, pause/resume and clear, and flags expiry to the game FSM.
- Drives the same digit outputs (min, sec_high, sec_low) consumed by the 7-segment display path.

Parameters:
- TICK_DIV, 50000000: system clocks per one-second tick; must be >= 2. Set to 4 in simulation.
- DEF_MIN, 1: minutes digit value after reset or clear (0-9).
- DEF_SEC_HIGH, 0: tens-of-seconds digit after reset or clear (0-5).
- DEF_SEC_LOW, 0: units-of-seconds digit after reset or clear (0-9).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  level; sampled each cycle; start/resume request.
- pause  in  1  level; sampled each cycle; pause request.
- clear  in  1  abort and restore the default time.
- load  in  1  load the ld_* digits.
- ld_min  in  4  BCD minutes to load.
- ld_sec_high  in  4  BCD tens of seconds to load.
- ld_sec_low  in  4  BCD units of seconds to load.
- min  out  4  current minutes digit.
- sec_high  out  4  current tens-of-seconds digit.
- sec_low  out  4  current units-of-seconds digit.
- running  out  1  high while in RUN.
- paused  out  1  high while in PAUSE.
- tick  out  1  one-cycle pulse on each decrement.
- time_up  out  1  one-cycle pulse on entering DONE.
- expired  out  1  level; high while in DONE.
- load_err  out  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset (rst_n low at an edge):
  - state = IDLE; prescaler = 0.
  - Digits = DEF_MIN:DEF_SEC_HIGH DEF_SEC_LOW.
  - All status outputs and pulses = 0.
- States: IDLE, RUN, PAUSE, DONE. Registered encoding; outputs decoded from registers, no combinational path from inputs to outputs.
- Command priority per cycle: clear > load > pause > start.
- clear (any state):
  - Next state IDLE; digits = defaults; prescaler = 0.
  - No tick or time_up that cycle, even if a tick was due.
- load (accepted in IDLE or DONE only; ignored in RUN and PAUSE):
  - Valid when ld_sec_high <= 5, ld_sec_low <= 9 and ld_min <= 9.
  - Valid load: digits take the ld_* values next edge; state becomes IDLE; prescaler = 0.
  - Invalid load: digits unchanged; load_err pulses 1 cycle.
- start:
  - IDLE -> RUN, but only if the digits are not 0:00. At 0:00 start is ignored and the state stays IDLE.
  - PAUSE -> RUN (resume). Prescaler is kept, not reset.
  - Ignored in RUN and DONE.
- pause:
  - RUN -> PAUSE. Prescaler and digits frozen.
  - Ignored in other states.
- Prescaler (RUN only):
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - On the edge where it equals TICK_DIV-1: digits decrement and tick = 1 for the following cycle.
  - The first decrement occurs TICK_DIV cycles after the start edge.
- BCD decrement:
  - If sec_low > 0: sec_low - 1.
  - Else sec_low = 9, and:
    - if sec_high > 0: sec_high - 1;
    - else sec_high = 5 and min - 1.
  - Never underflows: RUN is never entered at 0:00.
- Expiry:
  - When a decrement produces 0:00, the same edge sets state DONE.
  - time_up and tick are both 1 for that following cycle; expired stays 1 from then on.
- DONE:
  - Digits hold at 0:00.
  - Left only by clear, a valid load, or reset.
- Simultaneous events:
  - pause and a due tick on the same edge: pause wins; no decrement; prescaler holds at TICK_DIV-1.
  - After resume, the decrement fires on the first RUN edge.
- Reset mid-RUN: same as power-on reset; no time_up generated.

Test Plan (TICK_DIV=4, defaults 1:00):
- Reset, then check outputs -> min=1, sec_high=0, sec_low=0; running=0, expired=0, all pulses 0.
- Load 0:02, start at cycle 0 -> tick at cycles 4 and 8; digits 0:01 after cycle 4, 0:00 after cycle 8; time_up a single pulse coincident with the second tick; expired=1 afterwards; further start ignored.
- From 1:00, run one tick -> digits 0:59 (borrow across both digits); one more tick -> 0:58.
- Run, pause at prescaler=2 for 10 cycles, then resume -> no tick during the pause; next tick 2 cycles after resume (prescaler continues 2->3); paused=1 only during the pause.
- Load 0:75 in IDLE -> load_err pulses 1 cycle, digits unchanged. Load 0:00 then start -> stays IDLE, running=0.
- clear asserted on the same cycle a tick is due in RUN -> no tick; next cycle state IDLE, digits 1:00. Also in RUN, load 0:30 -> ignored, digits keep counting.

Source files
------------

// File: rtl/m_round_timer_ctrl.sv
// Game-round countdown timer: divides clk into a one-second enable and counts a
// BCD M:SS register down to 0:00, with load/start/pause/clear and expiry flags.
module m_round_timer_ctrl #(
  parameter int TICK_DIV     = 50000000,
  parameter int DEF_MIN      = 1,
  parameter int DEF_SEC_HIGH = 0,
  parameter int DEF_SEC_LOW  = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pause,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] ld_min,
  input  logic [3:0] ld_sec_high,
  input  logic [3:0] ld_sec_low,
  output logic [3:0] min,
  output logic [3:0] sec_high,
  output logic [3:0] sec_low,
  output logic       running,
  output logic       paused,
  output logic       tick,
  output logic       time_up,
  output logic       expired,
  output logic       load_err
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PS_MAX = PW'(TICK_DIV - 1);
  localparam logic [3:0] D_MIN = 4'(DEF_MIN);
  localparam logic [3:0] D_SH  = 4'(DEF_SEC_HIGH);
  localparam logic [3:0] D_SL  = 4'(DEF_SEC_LOW);

  state_t        state, state_d;
  logic [PW-1:0] prescaler, prescaler_d;
  logic [3:0]    min_d, sec_high_d, sec_low_d;
  logic [3:0]    dec_min, dec_sec_high, dec_sec_low;
  logic          tick_d, time_up_d, load_err_d;
  logic          ld_valid, at_zero, dec_zero, load_ok_state;

  assign ld_valid      = (ld_min <= 4'd9) && (ld_sec_high <= 4'd5) && (ld_sec_low <= 4'd9);
  assign at_zero       = ({min, sec_high, sec_low} == 12'h000);
  assign dec_zero      = ({dec_min, dec_sec_high, dec_sec_low} == 12'h000);
  assign load_ok_state = (state == IDLE) || (state == DONE);

  // BCD borrow chain; RUN is never entered at 0:00 so min never underflows
  always_comb begin
    dec_min      = min;
    dec_sec_high = sec_high;
    dec_sec_low  = sec_low;
    if (sec_low != 4'd0) begin
      dec_sec_low = sec_low - 4'd1;
    end else begin
      dec_sec_low = 4'd9;
      if (sec_high != 4'd0) begin
        dec_sec_high = sec_high - 4'd1;
      end else begin
        dec_sec_high = 4'd5;
        dec_min      = min - 4'd1;
      end
    end
  end

  // Commands resolve clear > load > pause > start; a load only claims the cycle
  // in states where it can be accepted
  always_comb begin
    state_d     = state;
    prescaler_d = prescaler;
    min_d       = min;
    sec_high_d  = sec_high;
    sec_low_d   = sec_low;
    tick_d      = 1'b0;
    time_up_d   = 1'b0;
    load_err_d  = 1'b0;
    if (clear) begin
      state_d     = IDLE;
      prescaler_d = '0;
      min_d       = D_MIN;
      sec_high_d  = D_SH;
      sec_low_d   = D_SL;
    end else if (load && load_ok_state) begin
      if (ld_valid) begin
        state_d     = IDLE;
        prescaler_d = '0;
        min_d       = ld_min;
        sec_high_d  = ld_sec_high;
        sec_low_d   = ld_sec_low;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (pause && (state == RUN)) begin
      state_d = PAUSE;
    end else if (start && (state == IDLE) && !at_zero) begin
      state_d = RUN;
    end else if (start && (state == PAUSE)) begin
      state_d = RUN;
    end else if (state == RUN) begin
      if (prescaler == PS_MAX) begin
        prescaler_d = '0;
        min_d       = dec_min;
        sec_high_d  = dec_sec_high;
        sec_low_d   = dec_sec_low;
        tick_d      = 1'b1;
        if (dec_zero) begin
          state_d   = DONE;
          time_up_d = 1'b1;
        end
      end else begin
        prescaler_d = prescaler + PW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      prescaler <= '0;
      min       <= D_MIN;
      sec_high  <= D_SH;
      sec_low   <= D_SL;
      tick      <= 1'b0;
      time_up   <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      state     <= state_d;
      prescaler <= prescaler_d;
      min       <= min_d;
      sec_high  <= sec_high_d;
      sec_low   <= sec_low_d;
      tick      <= tick_d;
      time_up   <= time_up_d;
      load_err  <= load_err_d;
    end
  end

  assign running = (state == RUN);
  assign paused  = (state == PAUSE);
  assign expired = (state == DONE);

endmodule
